// File: rtl/pid_drive_if.sv
// Handshake bundle between the error source and pid_drive_ctrl.
// The master drives error samples; the slave returns the drive magnitude.
interface pid_drive_if #(
  parameter int ERR_W = 13,
  parameter int OUT_W = 12
);
  logic [ERR_W-1:0] error;
  logic             err_vld;
  logic             not_pedaling;
  logic [1:0]       mode;
  logic [OUT_W-1:0] drv_mag;
  logic             drv_vld;

  modport master (
    output error, err_vld, not_pedaling, mode,
    input  drv_mag, drv_vld
  );

  modport slave (
    input  error, err_vld, not_pedaling, mode,
    output drv_mag, drv_vld
  );
endinterface

// File: rtl/pid_drive_ctrl.sv
// Decimated PID drive controller: signed error in, unsigned drive magnitude out, 2-cycle pipeline.
// Optional output slew limiter enabled by defining PID_SLEW_LIMIT_EN.
module pid_drive_ctrl #(
  parameter int ERR_W     = 13,
  parameter int OUT_W     = 12,
  parameter int INT_W     = 18,
  parameter int DEC_BITS  = 20,
  parameter int FAST_SIM  = 0,
  parameter int FAST_BITS = 15,
  parameter int D_DEPTH   = 3,
  parameter int D_SAT_W   = 9,
  parameter int D_SHIFT   = 1,
  parameter int SLEW      = 64
) (
  input logic      clk,
  input logic      rst,
  pid_drive_if.slave bus
);
  localparam int S_W = ((ERR_W > OUT_W) ? ERR_W : OUT_W) + 2;
  localparam logic signed [ERR_W:0] D_MAX = {{(ERR_W + 2 - D_SAT_W){1'b0}}, {(D_SAT_W - 1){1'b1}}};
  localparam logic signed [ERR_W:0] D_MIN = {{(ERR_W + 2 - D_SAT_W){1'b1}}, {(D_SAT_W - 1){1'b0}}};
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W - 1){1'b1}}};

  if (D_DEPTH < 1 || SLEW < 1) begin : g_bad_param
    $error("pid_drive_ctrl: D_DEPTH and SLEW must be at least 1");
  end

  logic [DEC_BITS-1:0]   cnt_q, cnt_d;
  logic [INT_W-1:0]      integ_q, integ_d;
  logic [ERR_W-1:0]      hist_q [D_DEPTH];
  logic [ERR_W-1:0]      hist_d [D_DEPTH];
  logic signed [S_W-1:0] sum_q, sum_d;
  logic                  vld1_q, vld1_d;
  logic [OUT_W-1:0]      drv_mag_q, drv_mag_d;
  logic                  drv_vld_q, drv_vld_d;

  logic                  tick_s, upd_s, upd_tick_s;
  logic signed [INT_W:0] int_sum_s;
  logic signed [ERR_W:0] d_diff_s;
  logic signed [D_SAT_W-1:0] d_sat_s;
  logic signed [S_W-1:0] pterm_s, iterm_s, dterm_s;
  logic [OUT_W-1:0]      clamp_s, target_s;

  // Decimator tick, integrator clamp and derivative history shift
  always_comb begin
    cnt_d = cnt_q + {{(DEC_BITS - 1){1'b0}}, 1'b1};
    if (FAST_SIM != 0) begin
      tick_s = &cnt_q[FAST_BITS-1:0];
    end else begin
      tick_s = &cnt_q;
    end
    upd_s      = bus.err_vld && (bus.mode != 2'd3);
    upd_tick_s = upd_s && tick_s;

    // Integrator is kept non-negative, so one extra bit is enough to see both clamp cases
    int_sum_s = $signed({integ_q[INT_W-1], integ_q})
              + $signed({{(INT_W + 1 - ERR_W){bus.error[ERR_W-1]}}, bus.error});
    if (bus.not_pedaling) begin
      integ_d = '0;
    end else if (upd_tick_s) begin
      if (int_sum_s[INT_W]) begin
        integ_d = '0;
      end else if (int_sum_s[INT_W-1]) begin
        integ_d = INT_MAX;
      end else begin
        integ_d = int_sum_s[INT_W-1:0];
      end
    end else begin
      integ_d = integ_q;
    end

    if (upd_tick_s) begin
      hist_d[0] = bus.error;
      for (int i = 1; i < D_DEPTH; i++) hist_d[i] = hist_q[i-1];
    end else begin
      for (int i = 0; i < D_DEPTH; i++) hist_d[i] = hist_q[i];
    end
  end

  // Stage 1: form P, I, D terms from the pre-update state and gate them by mode
  always_comb begin
    pterm_s  = $signed({{(S_W - ERR_W){bus.error[ERR_W-1]}}, bus.error});
    d_diff_s = $signed({bus.error[ERR_W-1], bus.error})
             - $signed({hist_q[D_DEPTH-1][ERR_W-1], hist_q[D_DEPTH-1]});
    if (d_diff_s > D_MAX) begin
      d_sat_s = D_MAX[D_SAT_W-1:0];
    end else if (d_diff_s < D_MIN) begin
      d_sat_s = D_MIN[D_SAT_W-1:0];
    end else begin
      d_sat_s = d_diff_s[D_SAT_W-1:0];
    end
    iterm_s = $signed({{(S_W - OUT_W){1'b0}}, integ_q[INT_W-2 -: OUT_W]});
    dterm_s = $signed({{(S_W - D_SAT_W){d_sat_s[D_SAT_W-1]}}, d_sat_s}) <<< D_SHIFT;
    case (bus.mode)
      2'd0:    sum_d = pterm_s + iterm_s + dterm_s;
      2'd1:    sum_d = pterm_s + iterm_s;
      2'd2:    sum_d = pterm_s;
      default: sum_d = pterm_s;
    endcase
    vld1_d = upd_s;
  end

  // Stage 2: clamp to the unsigned output range, optionally slew-limit toward it
  always_comb begin
    if (sum_q[S_W-1]) begin
      clamp_s = '0;
    end else if (|sum_q[S_W-2:OUT_W]) begin
      clamp_s = '1;
    end else begin
      clamp_s = sum_q[OUT_W-1:0];
    end
`ifdef PID_SLEW_LIMIT_EN
    begin : slew_blk
      logic [OUT_W-1:0] step_v, lim_v;
      if (clamp_s > drv_mag_q) begin
        step_v = clamp_s - drv_mag_q;
      end else begin
        step_v = drv_mag_q - clamp_s;
      end
      lim_v = (step_v > OUT_W'(SLEW)) ? OUT_W'(SLEW) : step_v;
      if (clamp_s > drv_mag_q) begin
        target_s = drv_mag_q + lim_v;
      end else begin
        target_s = drv_mag_q - lim_v;
      end
    end
`else
    target_s = clamp_s;
`endif
    drv_mag_d = vld1_q ? target_s : drv_mag_q;
    drv_vld_d = vld1_q;
  end

  // State registers with synchronous reset; reset also drops in-flight samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      integ_q   <= '0;
      for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
      sum_q     <= '0;
      vld1_q    <= 1'b0;
      drv_mag_q <= '0;
      drv_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      integ_q   <= integ_d;
      hist_q    <= hist_d;
      sum_q     <= sum_d;
      vld1_q    <= vld1_d;
      drv_mag_q <= drv_mag_d;
      drv_vld_q <= drv_vld_d;
    end
  end

  assign bus.drv_mag = drv_mag_q;
  assign bus.drv_vld = drv_vld_q;
endmodule

// File: tb/tb_pid_drive_ctrl.sv
// Self-checking bench for pid_drive_ctrl: a reference model pushes expected outputs to a
// queue at sample time, a monitor pops them on drv_vld; scenario tasks add directed checks.
module tb_pid_drive_ctrl;
  localparam int FB = 6;  // tick every 64 cycles keeps the saturation run short

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pid_drive_if #(.ERR_W(13), .OUT_W(12)) bus_if ();

  pid_drive_ctrl #(.FAST_SIM(1), .FAST_BITS(FB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct { int due; int val; } sb_t;
  sb_t sbq[$];

  int  nerr = 0;
  int  nchk = 0;
  int  cyc = 0;
  int  mdl_cnt = 0;
  int  mdl_int = 0;
  int  mdl_hist[3];
  bit  mdl_rst_d = 1'b0;
  int  mdl_last = 0;
  bit  mon_en = 1'b0;
  sb_t mon_it;
  int  mon_exp;
  bit  mon_ev;

  int   err_i;
  logic mdl_upd, mdl_tick;
  assign err_i    = int'($signed(bus_if.error));
  assign mdl_upd  = bus_if.err_vld && (bus_if.mode != 2'd3);
  assign mdl_tick = ((mdl_cnt % (1 << FB)) == ((1 << FB) - 1));

  function automatic int exp_sum(int e, int integ, int prev, int m);
    int d, s;
    d = e - prev;
    if (d > 255) d = 255;
    else if (d < -256) d = -256;
    d = d * 2;
    s = e;
    if (m != 2) s = s + integ / 32;
    if (m == 0) s = s + d;
    if (s < 0) s = 0;
    else if (s > 4095) s = 4095;
    return s;
  endfunction

  function automatic int int_clamp(int v);
    if (v < 0) return 0;
    if (v > 131071) return 131071;
    return v;
  endfunction

  function automatic int slew_f(int prev, int tgt);
    if (tgt > prev) return prev + ((tgt - prev > 64) ? 64 : tgt - prev);
    return prev - ((prev - tgt > 64) ? 64 : prev - tgt);
  endfunction

  function automatic sb_t mk_item(int due, int val);
    sb_t it;
    it.due = due;
    it.val = val;
    return it;
  endfunction

  // Reference model: samples inputs at the same edge as the DUT
  always @(posedge clk) begin
    mdl_rst_d <= rst;
    cyc <= cyc + 1;
    if (rst) begin
      mdl_cnt <= 0;
      mdl_int <= 0;
      for (int i = 0; i < 3; i++) mdl_hist[i] <= 0;
      sbq.delete();
    end else begin
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_upd) sbq.push_back(mk_item(cyc + 2, exp_sum(err_i, mdl_int, mdl_hist[2], int'(bus_if.mode))));
      if (bus_if.not_pedaling) mdl_int <= 0;
      else if (mdl_upd && mdl_tick) mdl_int <= int_clamp(mdl_int + err_i);
      if (mdl_upd && mdl_tick) begin
        mdl_hist[0] <= err_i;
        mdl_hist[1] <= mdl_hist[0];
        mdl_hist[2] <= mdl_hist[1];
      end
    end
  end

  // Monitor: every cycle compares drv_vld and drv_mag against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (mdl_rst_d) mdl_last = 0;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        nchk++; nerr++;
        $display("FAIL sb_stale: sample due %0d never output (now %0d)", sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
      mon_ev = (sbq.size() > 0 && sbq[0].due == cyc);
      nchk++;
      if (bus_if.drv_vld !== mon_ev) begin
        nerr++;
        $display("FAIL sb_vld: cycle %0d got %0b want %0b", cyc, bus_if.drv_vld, mon_ev);
      end
      if (mon_ev) begin
        mon_it = sbq.pop_front();
`ifdef PID_SLEW_LIMIT_EN
        mon_exp = slew_f(mdl_last, mon_it.val);
`else
        mon_exp = mon_it.val;
`endif
        mdl_last = mon_exp;
      end else begin
        mon_exp = mdl_last;
      end
      nchk++;
      if (bus_if.drv_mag !== 12'(mon_exp)) begin
        nerr++;
        $display("FAIL sb_mag: cycle %0d got %0d want %0d", cyc, bus_if.drv_mag, mon_exp);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus_if.error = 13'd0; bus_if.err_vld = 1'b0; bus_if.not_pedaling = 1'b0; bus_if.mode = 2'd0;
    repeat (3) @(negedge clk);
    nchk++;
    if (bus_if.drv_mag !== 12'd0 || bus_if.drv_vld !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: got mag=%0d vld=%0b want 0/0", bus_if.drv_mag, bus_if.drv_vld);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_pid_basic();
    rst = 1'b0; bus_if.error = 13'd256; bus_if.mode = 2'd0; bus_if.err_vld = 1'b1;
    nchk++;
    if (bus_if.drv_vld !== 1'b0) begin nerr++; $display("FAIL basic_vld_c0: got %0b want 0", bus_if.drv_vld); end
    @(negedge clk);
    nchk++;
    if (bus_if.drv_vld !== 1'b0) begin nerr++; $display("FAIL basic_vld_c1: got %0b want 0", bus_if.drv_vld); end
    @(negedge clk);
    nchk++;
    if (bus_if.drv_vld !== 1'b1) begin nerr++; $display("FAIL basic_vld_c2: got %0b want 1", bus_if.drv_vld); end
`ifndef PID_SLEW_LIMIT_EN
    nchk++;
    if (bus_if.drv_mag !== 12'd766) begin nerr++; $display("FAIL basic_mag: got %0d want 766", bus_if.drv_mag); end
`endif
    repeat (8) @(negedge clk);
  endtask

  task automatic test_clamps();
    bus_if.error = 13'h1F9C; bus_if.mode = 2'd1;  // -100
    repeat (2) @(negedge clk);
`ifndef PID_SLEW_LIMIT_EN
    nchk++;
    if (bus_if.drv_mag !== 12'd0) begin nerr++; $display("FAIL neg_clamp: got %0d want 0", bus_if.drv_mag); end
`endif
    bus_if.error = 13'd4095; bus_if.mode = 2'd2;
    repeat (2) @(negedge clk);
`ifndef PID_SLEW_LIMIT_EN
    nchk++;
    if (bus_if.drv_mag !== 12'hFFF) begin nerr++; $display("FAIL pos_clamp: got %0d want 4095", bus_if.drv_mag); end
`endif
  endtask

  task automatic test_integrator();
    bit found;
    bus_if.err_vld = 1'b0; bus_if.not_pedaling = 1'b1;
    @(negedge clk);
    bus_if.not_pedaling = 1'b0; bus_if.error = 13'd1000; bus_if.mode = 2'd1; bus_if.err_vld = 1'b1;
    repeat (2) @(negedge clk);
`ifndef PID_SLEW_LIMIT_EN
    nchk++;
    if (bus_if.drv_mag !== 12'd1000) begin nerr++; $display("FAIL integ_pre_tick: got %0d want 1000", bus_if.drv_mag); end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus_if.drv_vld && bus_if.drv_mag != 12'd1000) found = 1'b1;
    end
    nchk++;
    if (!found || bus_if.drv_mag !== 12'd1031) begin
      nerr++; $display("FAIL integ_post_tick: got %0d (changed=%0b) want 1031", bus_if.drv_mag, found);
    end
`endif
    repeat (140 * (1 << FB)) @(negedge clk);
    bus_if.error = 13'd0;
    repeat (2) @(negedge clk);
`ifndef PID_SLEW_LIMIT_EN
    nchk++;
    if (bus_if.drv_mag !== 12'd4095) begin nerr++; $display("FAIL integ_sat: got %0d want 4095", bus_if.drv_mag); end
`endif
  endtask

  task automatic test_not_pedaling();
    bus_if.err_vld = 1'b0; bus_if.not_pedaling = 1'b1;
    @(negedge clk);
    bus_if.not_pedaling = 1'b0; bus_if.err_vld = 1'b1; bus_if.error = 13'd500; bus_if.mode = 2'd1;
    repeat (2) @(negedge clk);
`ifndef PID_SLEW_LIMIT_EN
    nchk++;
    if (bus_if.drv_mag !== 12'd500) begin nerr++; $display("FAIL np_clear: got %0d want 500", bus_if.drv_mag); end
`endif
    repeat (70) @(negedge clk);
  endtask

  task automatic test_hold();
    int nv;
    bus_if.mode = 2'd3; bus_if.error = 13'd2000;
    repeat (2) @(negedge clk);
    nv = 0;
    for (int i = 0; i < 98; i++) begin
      @(negedge clk);
      if (bus_if.drv_vld) nv++;
    end
    nchk++;
    if (nv != 0) begin nerr++; $display("FAIL hold_no_vld: got %0d pulses want 0", nv); end
    bus_if.mode = 2'd0;
    @(negedge clk);
    nchk++;
    if (bus_if.drv_vld !== 1'b0) begin nerr++; $display("FAIL hold_resume_c1: got %0b want 0", bus_if.drv_vld); end
    @(negedge clk);
    nchk++;
    if (bus_if.drv_vld !== 1'b1) begin nerr++; $display("FAIL hold_resume_c2: got %0b want 1", bus_if.drv_vld); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      bus_if.err_vld = 1'b1; bus_if.mode = 2'($urandom_range(0, 2)); bus_if.error = 13'($urandom);
      if (i >= 2 && bus_if.drv_vld) nv++;
      @(negedge clk);
    end
    bus_if.err_vld = 1'b0;
    if (bus_if.drv_vld) nv++;
    @(negedge clk);
    if (bus_if.drv_vld) nv++;
    nchk++;
    if (nv != 20) begin nerr++; $display("FAIL b2b_count: got %0d pulses want 20", nv); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus_if.error = 13'($urandom);
      bus_if.err_vld = ($urandom_range(0, 3) != 0);
      bus_if.mode = 2'($urandom_range(0, 3));
      bus_if.not_pedaling = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    bus_if.not_pedaling = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_if.error = 13'd300; bus_if.mode = 2'd2; bus_if.err_vld = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    if (bus_if.drv_vld !== 1'b0 || bus_if.drv_mag !== 12'd0) begin
      nerr++; $display("FAIL rstmid_c1: got vld=%0b mag=%0d want 0/0", bus_if.drv_vld, bus_if.drv_mag);
    end
    @(negedge clk);
    nchk++;
    if (bus_if.drv_vld !== 1'b0) begin nerr++; $display("FAIL rstmid_c2: got %0b want 0", bus_if.drv_vld); end
    @(negedge clk);
    nchk++;
    if (bus_if.drv_vld !== 1'b1) begin nerr++; $display("FAIL rstmid_c3: got %0b want 1", bus_if.drv_vld); end
`ifndef PID_SLEW_LIMIT_EN
    nchk++;
    if (bus_if.drv_mag !== 12'd300) begin nerr++; $display("FAIL rstmid_mag: got %0d want 300", bus_if.drv_mag); end
`endif
    repeat (4) @(negedge clk);
  endtask

`ifdef PID_SLEW_LIMIT_EN
  task automatic test_slew();
    int want;
    bus_if.mode = 2'd2; bus_if.error = 13'd0; bus_if.err_vld = 1'b1;
    repeat (80) @(negedge clk);
    bus_if.error = 13'd1000;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      want = (64 * k > 1000) ? 1000 : 64 * k;
      nchk++;
      if (bus_if.drv_vld !== 1'b1 || bus_if.drv_mag !== 12'(want)) begin
        nerr++; $display("FAIL slew_step%0d: got vld=%0b mag=%0d want 1/%0d", k, bus_if.drv_vld, bus_if.drv_mag, want);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pid_basic();
    test_clamps();
    test_integrator();
    test_not_pedaling();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef PID_SLEW_LIMIT_EN
    test_slew();
`endif
    bus_if.err_vld = 1'b0;
    repeat (5) @(negedge clk);
    nchk++;
    if (sbq.size() != 0) begin nerr++; $display("FAIL sb_drain: got %0d pending want 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
